data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the single core data-memory port (data_req/gnt/valid protocol) between two requesters: master 0 (the memory-stage load/store unit) and master 1 (debug/DMA access port).
- Round-robin arbitration of the address phase; an in-order ID FIFO routes each response back to the master that issued it.
- Sits between the memory stage and the data bus; adds no latency to the address phase.

Parameters:
- MAX_OUTST, 2, maximum number of granted-but-unanswered transactions (ID FIFO depth, 1..4).
- CW, $clog2(MAX_OUTST+1), width of the outstanding counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  master request
- m0_wr / m1_wr  in  1  1 = store, 0 = load
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  store data
- m0_be / m1_be  in  4  byte enables
- m0_gnt / m1_gnt  out  1  address phase accepted
- m0_rdata / m1_rdata  out  32  response data
- m0_valid / m1_valid  out  1  response valid
- m0_err / m1_err  out  1  response error, qualified by valid
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_be  out  4  bus byte enables
- data_gnt  in  1  bus grant
- data_rdata  in  32  bus read data
- data_valid  in  1  bus response valid
- data_error  in  1  bus error, qualified by data_valid
- outst_cnt  out  CW  current outstanding count
- unexp_resp  out  1  sticky: data_valid seen with no outstanding transaction

Behaviour:
- Reset values: last_gnt = 1 (master 0 wins first), lock = 0, FIFO empty, outst_cnt = 0, unexp_resp = 0.
- Reset outputs: all gnt, valid and err outputs = 0; data_req = 0.
- Selection (combinational):
  - if lock = 1, the locked master;
  - else, if only one master requests, that master;
  - else, if both request, the master != last_gnt.
- full = (outst_cnt == MAX_OUTST). No pass-through when full, even if a pop occurs in the same cycle.
- data_req = sel_req & ~full.
- data_wr, data_addr, data_wdata and data_be are muxed from the selected master. They are all-zero when no master is selected.
- mX_gnt = data_req & data_gnt & (sel == X). The other master's gnt = 0.
- Lock: set when data_req = 1 and data_gnt = 0. Cleared on the handshake (data_req & data_gnt). While locked, selection is frozen; this keeps address-phase stability.
- Handshake cycle: push sel ID into the FIFO and set last_gnt = sel.
- Response routing:
  - data_valid with FIFO non-empty pops the head ID H.
  - mH_valid = 1; mH_err = data_error.
  - Both rdata outputs carry data_rdata; the non-owner's valid and err = 0.
- Simultaneous push and pop in one cycle: outst_cnt unchanged; FIFO pointers wrap modulo MAX_OUTST.
- data_valid with FIFO empty: response dropped, no mX_valid, unexp_resp set to 1. unexp_resp clears only on reset.
- A master that drops req before its gnt is a protocol violation. While locked, the arbiter keeps driving the locked master's current bus fields.
- Reset mid-operation: all state cleared immediately; outstanding responses are lost. Masters must also be reset.
- Responses are strictly in order; no response reordering.

Test Plan:
- Only m0 requests a load, addr 0x100, gnt same cycle, valid 2 cycles later with rdata 0xDEADBEEF -> m0_gnt pulses 1 cycle; m0_valid = 1 with rdata 0xDEADBEEF; m1_valid stays 0; outst_cnt goes 0->1->0.
- m0 and m1 request continuously, data_gnt = 1 always, data_valid 1 cycle after each gnt -> grants alternate m0,m1,m0,m1; each response lands on the matching master in issue order.
- m1 requests with data_gnt held 0 for 3 cycles while m0 raises req in cycle 2 -> data_addr stays at m1's address; m1 is granted in cycle 4; m0 is granted next.
- MAX_OUTST = 2, two grants with no responses -> outst_cnt = 2; data_req = 0 while full; the first data_valid re-enables data_req the following cycle.
- Response with data_error = 1 to an m1 store -> m1_valid = 1, m1_err = 1, m0_err = 0.
- data_valid pulsed with outst_cnt = 0 -> no master valid; unexp_resp = 1 until reset_n low. Assert reset_n low with 2 outstanding -> outst_cnt = 0 and last_gnt = 1 asynchronously.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the core data-memory port (req/gnt/valid protocol).
// An in-order ID FIFO routes each bus response back to the master that issued it.
module data_bus_arbiter #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  // master 0: memory-stage load/store unit
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_be,
  output logic          m0_gnt,
  output logic [31:0]   m0_rdata,
  output logic          m0_valid,
  output logic          m0_err,
  // master 1: debug/DMA access port
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_be,
  output logic          m1_gnt,
  output logic [31:0]   m1_rdata,
  output logic          m1_valid,
  output logic          m1_err,
  // shared data bus
  output logic          data_req,
  output logic          data_wr,
  output logic [31:0]   data_addr,
  output logic [31:0]   data_wdata,
  output logic [3:0]    data_be,
  input  logic          data_gnt,
  input  logic [31:0]   data_rdata,
  input  logic          data_valid,
  input  logic          data_error,
  // status
  output logic [CW-1:0] outst_cnt,
  output logic          unexp_resp
);

  localparam int unsigned   PW      = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [PW-1:0] PtrLast = PW'(MAX_OUTST - 1);
  localparam logic [CW-1:0] CntFull = CW'(MAX_OUTST);

  logic                 last_gnt_q, last_gnt_d;
  logic                 lock_q, lock_d;
  logic                 lock_id_q, lock_id_d;
  logic [MAX_OUTST-1:0] id_q, id_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 unexp_q, unexp_d;

  logic sel_vld;
  logic sel_id;
  logic full;
  logic push;
  logic pop;
  logic head_id;

  // Selection: a locked address phase keeps its master until the handshake.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = 1'b0;
    if (lock_q) begin
      sel_vld = 1'b1;
      sel_id  = lock_id_q;
    end else if (m0_req && m1_req) begin
      sel_vld = 1'b1;
      sel_id  = ~last_gnt_q;
    end else if (m0_req) begin
      sel_vld = 1'b1;
      sel_id  = 1'b0;
    end else if (m1_req) begin
      sel_vld = 1'b1;
      sel_id  = 1'b1;
    end
  end

  always_comb begin
    data_wr    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    data_be    = '0;
    if (sel_vld) begin
      if (sel_id) begin
        data_wr    = m1_wr;
        data_addr  = m1_addr;
        data_wdata = m1_wdata;
        data_be    = m1_be;
      end else begin
        data_wr    = m0_wr;
        data_addr  = m0_addr;
        data_wdata = m0_wdata;
        data_be    = m0_be;
      end
    end
  end

  // A pop in the same cycle does not free a slot for pass-through.
  assign full     = (cnt_q == CntFull);
  assign data_req = sel_vld & ~full;
  assign push     = data_req & data_gnt;
  assign pop      = data_valid & (cnt_q != '0);
  assign head_id  = id_q[rptr_q];

  assign m0_gnt   = push & ~sel_id;
  assign m1_gnt   = push & sel_id;

  assign m0_rdata = data_rdata;
  assign m1_rdata = data_rdata;
  assign m0_valid = pop & ~head_id;
  assign m1_valid = pop & head_id;
  assign m0_err   = m0_valid & data_error;
  assign m1_err   = m1_valid & data_error;

  assign outst_cnt  = cnt_q;
  assign unexp_resp = unexp_q;

  always_comb begin
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    last_gnt_d = last_gnt_q;
    id_d       = id_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    unexp_d    = unexp_q;

    if (push) begin
      lock_d     = 1'b0;
      last_gnt_d = sel_id;
      id_d[wptr_q] = sel_id;
      wptr_d     = (wptr_q == PtrLast) ? '0 : wptr_q + PW'(1);
    end else if (data_req && !data_gnt) begin
      lock_d    = 1'b1;
      lock_id_d = sel_id;
    end

    if (pop) begin
      rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (data_valid && (cnt_q == '0)) begin
      unexp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= 1'b1;
      lock_q     <= 1'b0;
      lock_id_q  <= 1'b0;
      id_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      unexp_q    <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      id_q       <= id_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      unexp_q    <= unexp_d;
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: grants, lock, full stall, response routing, reset.
module tb_data_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_req, m0_wr, m0_gnt, m0_valid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_wr, m1_gnt, m1_valid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        data_req, data_wr, data_gnt, data_valid, data_error;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
  logic [1:0]  outst_cnt;
  logic        unexp_resp;

  int vectors;
  int errors;

  data_bus_arbiter #(.MAX_OUTST(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m0_req     (m0_req),
    .m0_wr      (m0_wr),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_be      (m0_be),
    .m0_gnt     (m0_gnt),
    .m0_rdata   (m0_rdata),
    .m0_valid   (m0_valid),
    .m0_err     (m0_err),
    .m1_req     (m1_req),
    .m1_wr      (m1_wr),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_be      (m1_be),
    .m1_gnt     (m1_gnt),
    .m1_rdata   (m1_rdata),
    .m1_valid   (m1_valid),
    .m1_err     (m1_err),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_be    (data_be),
    .data_gnt   (data_gnt),
    .data_rdata (data_rdata),
    .data_valid (data_valid),
    .data_error (data_error),
    .outst_cnt  (outst_cnt),
    .unexp_resp (unexp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    data_gnt = 0; data_rdata = '0; data_valid = 0; data_error = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #2;
    vectors++;
    if ({m0_gnt, m1_gnt, m0_valid, m1_valid, m0_err, m1_err, data_req, unexp_resp} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {m0_gnt, m1_gnt, m0_valid, m1_valid, m0_err, m1_err, data_req, unexp_resp});
    end
    vectors++;
    if (outst_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_outst: got %0d want 0", outst_cnt);
    end
    vectors++;
    if ({data_wr, data_addr, data_wdata, data_be} !== 69'd0) begin
      errors++; $display("FAIL idle_bus_fields: got addr %h want 0", data_addr);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single_load();
    do_reset();
    m0_req = 1; m0_addr = 32'h100; data_gnt = 1;
    #1;
    vectors++;
    if ({data_req, m0_gnt, m1_gnt, data_wr, data_addr} !== {4'b1100, 32'h100}) begin
      errors++;
      $display("FAIL single_grant: got req/g0/g1/wr %b addr %h want 1100 100",
               {data_req, m0_gnt, m1_gnt, data_wr}, data_addr);
    end
    tick();
    m0_req = 0; data_gnt = 0;
    #1;
    vectors++;
    if ({m0_gnt, outst_cnt} !== {1'b0, 2'd1}) begin
      errors++; $display("FAIL single_outst1: got gnt %b cnt %0d want 0 1", m0_gnt, outst_cnt);
    end
    tick();
    data_valid = 1; data_rdata = 32'hDEADBEEF;
    #1;
    vectors++;
    if ({m0_valid, m1_valid, m0_err, m0_rdata} !== {3'b100, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_resp: got v0/v1/e0 %b rdata %h want 100 deadbeef",
               {m0_valid, m1_valid, m0_err}, m0_rdata);
    end
    tick();
    data_valid = 0;
    #1;
    vectors++;
    if (outst_cnt !== 2'd0) begin
      errors++; $display("FAIL single_outst0: got %0d want 0", outst_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_g, exp_v;
    logic [31:0] exp_rd;
    do_reset();
    m0_req = 1; m0_addr = 32'h200; m1_req = 1; m1_addr = 32'h300; data_gnt = 1;
    for (int k = 0; k < 6; k++) begin
      data_valid = (k > 0);
      exp_rd     = 32'hA000_0000 + k;
      data_rdata = exp_rd;
      #1;
      exp_g = (k % 2 == 1) ? 2'b01 : 2'b10;
      exp_v = (k == 0) ? 2'b00 : (((k - 1) % 2 == 1) ? 2'b01 : 2'b10);
      vectors++;
      if ({m0_gnt, m1_gnt} !== exp_g) begin
        errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, {m0_gnt, m1_gnt}, exp_g);
      end
      vectors++;
      if ({m0_valid, m1_valid} !== exp_v) begin
        errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, {m0_valid, m1_valid}, exp_v);
      end
      vectors++;
      if (outst_cnt !== ((k == 0) ? 2'd0 : 2'd1)) begin
        errors++; $display("FAIL b2b_outst[%0d]: got %0d want %0d", k, outst_cnt, (k == 0) ? 0 : 1);
      end
      tick();
    end
    m0_req = 0; m1_req = 0; data_valid = 1; exp_rd = 32'hA000_0006; data_rdata = exp_rd;
    #1;
    vectors++;
    if ({data_req, m0_valid, m1_valid, m1_rdata} !== {3'b001, exp_rd}) begin
      errors++;
      $display("FAIL b2b_last: got req/v0/v1 %b rdata %h want 001 %h",
               {data_req, m0_valid, m1_valid}, m1_rdata, exp_rd);
    end
    tick();
    data_valid = 0;
    #1;
    vectors++;
    if (outst_cnt !== 2'd0) begin
      errors++; $display("FAIL b2b_drain: got %0d want 0", outst_cnt);
    end
  endtask

  task automatic test_lock();
    do_reset();
    m1_req = 1; m1_addr = 32'h400; m0_addr = 32'h500; data_gnt = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) m0_req = 1;
      #1;
      vectors++;
      if ({data_req, m0_gnt, m1_gnt, data_addr} !== {3'b100, 32'h400}) begin
        errors++;
        $display("FAIL lock_hold[%0d]: got req/g0/g1 %b addr %h want 100 400",
                 c, {data_req, m0_gnt, m1_gnt}, data_addr);
      end
      tick();
    end
    data_gnt = 1;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt, data_addr} !== {2'b01, 32'h400}) begin
      errors++;
      $display("FAIL lock_m1_gnt: got g0/g1 %b addr %h want 01 400", {m0_gnt, m1_gnt}, data_addr);
    end
    tick();
    m1_req = 0;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt, data_addr} !== {2'b10, 32'h500}) begin
      errors++;
      $display("FAIL lock_m0_next: got g0/g1 %b addr %h want 10 500", {m0_gnt, m1_gnt}, data_addr);
    end
    tick();
  endtask

  task automatic test_full();
    do_reset();
    m0_req = 1; m0_addr = 32'h800; data_gnt = 1;
    tick();
    tick();
    #1;
    vectors++;
    if ({outst_cnt, data_req, m0_gnt} !== {2'd2, 2'b00}) begin
      errors++;
      $display("FAIL full_stall: got cnt %0d req %b gnt %b want 2 0 0", outst_cnt, data_req, m0_gnt);
    end
    tick();
    data_valid = 1; data_rdata = 32'h1111_2222;
    #1;
    vectors++;
    if ({data_req, m0_gnt, m0_valid} !== 3'b001) begin
      errors++;
      $display("FAIL full_no_passthru: got req/gnt/v0 %b want 001", {data_req, m0_gnt, m0_valid});
    end
    tick();
    data_valid = 0;
    #1;
    vectors++;
    if ({outst_cnt, data_req, m0_gnt} !== {2'd1, 2'b11}) begin
      errors++;
      $display("FAIL full_reenable: got cnt %0d req %b gnt %b want 1 1 1", outst_cnt, data_req, m0_gnt);
    end
    tick();
  endtask

  task automatic test_error();
    do_reset();
    m1_req = 1; m1_wr = 1; m1_addr = 32'h600; m1_wdata = 32'h1234_5678; m1_be = 4'b0011;
    data_gnt = 1;
    #1;
    vectors++;
    if ({m1_gnt, data_wr, data_wdata, data_be} !== {2'b11, 32'h1234_5678, 4'b0011}) begin
      errors++;
      $display("FAIL err_store_fields: got g1/wr %b wdata %h be %b want 11 12345678 0011",
               {m1_gnt, data_wr}, data_wdata, data_be);
    end
    tick();
    m1_req = 0; data_gnt = 0; data_valid = 1; data_error = 1;
    #1;
    vectors++;
    if ({m1_valid, m1_err, m0_valid, m0_err} !== 4'b1100) begin
      errors++;
      $display("FAIL err_route: got v1/e1/v0/e0 %b want 1100", {m1_valid, m1_err, m0_valid, m0_err});
    end
    tick();
    data_valid = 0; data_error = 0;
  endtask

  task automatic test_unexpected_and_reset();
    do_reset();
    data_valid = 1; data_rdata = 32'h5555_AAAA;
    #1;
    vectors++;
    if ({m0_valid, m1_valid, m0_err, m1_err} !== 4'b0000) begin
      errors++;
      $display("FAIL unexp_dropped: got v0/v1/e0/e1 %b want 0000", {m0_valid, m1_valid, m0_err, m1_err});
    end
    tick();
    data_valid = 0;
    #1;
    vectors++;
    if ({unexp_resp, outst_cnt} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL unexp_set: got %b cnt %0d want 1 0", unexp_resp, outst_cnt);
    end
    tick();
    tick();
    vectors++;
    if (unexp_resp !== 1'b1) begin
      errors++; $display("FAIL unexp_sticky: got %b want 1", unexp_resp);
    end
    // m1 then m0, so last_gnt ends at 0 before the asynchronous reset
    m1_req = 1; m1_addr = 32'h700; data_gnt = 1;
    #1;
    vectors++;
    if (m1_gnt !== 1'b1) begin
      errors++; $display("FAIL rst_pre_m1: got %b want 1", m1_gnt);
    end
    tick();
    m1_req = 0; m0_req = 1; m0_addr = 32'h900;
    #1;
    vectors++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL rst_pre_m0: got %b want 1", m0_gnt);
    end
    tick();
    m0_req = 0; data_gnt = 0;
    #1;
    vectors++;
    if (outst_cnt !== 2'd2) begin
      errors++; $display("FAIL rst_pre_outst: got %0d want 2", outst_cnt);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({outst_cnt, unexp_resp} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got cnt %0d unexp %b want 0 0", outst_cnt, unexp_resp);
    end
    #1;
    reset_n = 1'b1;
    tick();
    m0_req = 1; m1_req = 1; data_gnt = 1;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL rst_last_gnt: got g0/g1 %b want 10", {m0_gnt, m1_gnt});
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    idle_inputs();
    reset_n = 1'b1;
    test_reset();
    test_single_load();
    test_back_to_back();
    test_lock();
    test_full();
    test_error();
    test_unexpected_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
